iter_muldiv_alu: RTL and testbench

- Multi-cycle multiply/divide unit that extends the single-cycle ALU with the RV32M operations, parametrised in datapath width.
- It sits beside the existing single-cycle ALU in the execute stage.
- It uses a valid/ready handshake on both the operand side and the result side, so the core can stall while an operation is running.
- Multiply uses iterative shift-add and divide uses restoring division, one bit per cycle.

---
 rtl/iter_muldiv_alu.sv | 233 +++++++++++++++++++++++
 tb/tb_iter_muldiv_alu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_muldiv_alu.sv
// ---------------------------------------------------------------------------
// iter_muldiv_alu
//   Multi-cycle RV32M multiply/divide unit. Multiply is shift-add and divide
//   is restoring division, one bit per cycle, on operand magnitudes with a
//   sign fix-up on the final cycle. Divide-by-zero and signed overflow skip
//   the iteration and go straight to DONE.
//
//   Optional feature macro: MDU_FAST_MUL_EN
//     defined   -> all multiplies use a combinational XLEN x XLEN multiplier
//                  and complete one cycle after accept.
//     undefined -> multiplies iterate for XLEN cycles like divides.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operands/func valid       in_ready  unit idle, can accept
//   A, B       rs1 / rs2 operands        func      RV32M funct3
//   out_valid  Q holds a result          out_ready consumer takes result
//   Q          result                    busy      operation in progress
// ---------------------------------------------------------------------------
module iter_muldiv_alu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      func,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Q,
  output logic            busy
);

  localparam logic [XLEN-1:0]   ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2*XLEN-1:0] ZERO2    = {(2*XLEN){1'b0}};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // rs1 is treated as signed for MULH, MULHSU, DIV, REM
  function automatic logic f_a_signed(input logic [2:0] f);
    return (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd6);
  endfunction

  // rs2 is treated as signed for MULH, DIV, REM
  function automatic logic f_b_signed(input logic [2:0] f);
    return (f == 3'd1) || (f == 3'd4) || (f == 3'd6);
  endfunction

  function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? (ZERO - v) : v;
  endfunction

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_func;
  logic [XLEN-1:0]   r_opb;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]   r_hi;    // product high half / partial remainder
  logic [XLEN-1:0]   r_lo;    // multiplier->product low half / dividend->quotient
  logic              r_neg_q; // product or quotient must be negated
  logic              r_neg_r; // remainder must be negated

  logic              w_accept;
  logic              w_a_sgn;
  logic              w_b_sgn;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_fast;
  logic              w_bypass;
  logic [XLEN-1:0]   w_bypass_q;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [XLEN-1:0]   w_next_hi;
  logic [XLEN-1:0]   w_next_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_calc_q;

  assign w_accept   = in_valid & in_ready;
  assign w_a_sgn    = f_a_signed(func);
  assign w_b_sgn    = f_b_signed(func);
  assign w_div_zero = func[2] & (B == ZERO);
  // signed divides only (funct3 4 and 6 have bit 0 clear)
  assign w_div_ovf  = func[2] & ~func[0] & (A == MIN_NEG) & (B == ONES);

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_a;
  logic [2*XLEN-1:0] w_fast_b;
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_a    = w_a_sgn ? {{XLEN{A[XLEN-1]}}, A} : {ZERO, A};
  assign w_fast_b    = w_b_sgn ? {{XLEN{B[XLEN-1]}}, B} : {ZERO, B};
  assign w_fast_prod = w_fast_a * w_fast_b;
`endif

  // Results that are known at accept time and skip the iteration
  always_comb begin
    w_bypass_q = ZERO;
    w_fast     = 1'b0;
    if (w_div_zero) begin
      w_bypass_q = func[1] ? A : ONES;
    end else if (w_div_ovf) begin
      w_bypass_q = func[1] ? ZERO : A;
    end else begin
`ifdef MDU_FAST_MUL_EN
      w_fast     = ~func[2];
      w_bypass_q = (func[1:0] == 2'b00) ? w_fast_prod[XLEN-1:0] : w_fast_prod[2*XLEN-1:XLEN];
`else
      w_bypass_q = ZERO;
`endif
    end
  end

  assign w_bypass = w_div_zero | w_div_ovf | w_fast;

  // One iteration step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    w_sum     = {1'b0, r_hi} + ({1'b0, r_opb} & {(XLEN+1){r_lo[0]}});
    w_shift   = {r_hi, r_lo[XLEN-1]};
    w_ge      = (w_shift >= {1'b0, r_opb});
    // when w_ge holds the difference is below the divisor, so XLEN bits suffice
    w_diff    = w_shift[XLEN-1:0] - r_opb;
    w_next_hi = ZERO;
    w_next_lo = ZERO;
    if (r_func[2]) begin
      w_next_hi = w_ge ? w_diff : w_shift[XLEN-1:0];
      w_next_lo = {r_lo[XLEN-2:0], w_ge};
    end else begin
      w_next_hi = w_sum[XLEN:1];
      w_next_lo = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // Final sign correction and result selection on the last iteration
  always_comb begin
    w_prod = {w_next_hi, w_next_lo};
    if (r_neg_q) begin
      w_prod = ZERO2 - {w_next_hi, w_next_lo};
    end else begin
      w_prod = {w_next_hi, w_next_lo};
    end
    case (r_func)
      3'd0:             w_calc_q = w_prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: w_calc_q = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       w_calc_q = f_neg(w_next_lo, r_neg_q);
      3'd6, 3'd7:       w_calc_q = f_neg(w_next_hi, r_neg_r);
      default:          w_calc_q = ZERO;
    endcase
  end

  // Control FSM with registered handshake outputs and result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= CNT_ZERO;
      r_func    <= 3'd0;
      r_opb     <= ZERO;
      r_hi      <= ZERO;
      r_lo      <= ZERO;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      Q         <= ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_func   <= func;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_neg_q  <= (w_a_sgn & A[XLEN-1]) ^ (w_b_sgn & B[XLEN-1]);
            r_neg_r  <= w_a_sgn & A[XLEN-1];
            r_hi     <= ZERO;
            r_cnt    <= CNT_LAST;
            if (func[2]) begin
              r_opb <= f_neg(B, w_b_sgn & B[XLEN-1]);
              r_lo  <= f_neg(A, w_a_sgn & A[XLEN-1]);
            end else begin
              r_opb <= f_neg(A, w_a_sgn & A[XLEN-1]);
              r_lo  <= f_neg(B, w_b_sgn & B[XLEN-1]);
            end
            if (w_bypass) begin
              r_state   <= S_DONE;
              out_valid <= 1'b1;
              Q         <= w_bypass_q;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_next_hi;
          r_lo  <= w_next_lo;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ZERO) begin
            r_state   <= S_DONE;
            out_valid <= 1'b1;
            Q         <= w_calc_q;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state   <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_muldiv_alu.sv
// ---------------------------------------------------------------------------
// tb_iter_muldiv_alu
//   Directed bench for iter_muldiv_alu (XLEN=32). A monitor on the falling
//   edge predicts every result and its latency from a plain-arithmetic model
//   of the RV32M rules; directed calls also pin hand-computed literals.
// ---------------------------------------------------------------------------
module tb_iter_muldiv_alu;

  localparam int XLEN = 32;
`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [2:0]  func = 3'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] Q;
  logic        busy;

  int errors = 0;
  int checks = 0;

  iter_muldiv_alu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .func(func), .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result from RV32M rules using 64-bit arithmetic
  function automatic logic [31:0] model_q(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa_s, xb_s, xa_u, xb_u, p;
    logic [31:0] r;
    xa_s = {{32{a[31]}}, a};
    xb_s = {{32{b[31]}}, b};
    xa_u = {32'd0, a};
    xb_u = {32'd0, b};
    p = 64'd0;
    r = 32'd0;
    case (f)
      3'd0: begin p = xa_u * xb_u; r = p[31:0];  end
      3'd1: begin p = xa_s * xb_s; r = p[63:32]; end
      3'd2: begin p = xa_s * xb_u; r = p[63:32]; end
      3'd3: begin p = xa_u * xb_u; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
        else r = $signed(a) / $signed(b);
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
        else r = $signed(a) % $signed(b);
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Cycles from the accepting edge until out_valid is seen
  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
    if (FAST && !f[2]) return 1;
    return XLEN + 1;
  endfunction

  typedef struct {
    logic [31:0] q;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   edges = 0;
  bit   tracking = 1'b0;
  bit   seen_valid = 1'b0;
  bit   late_flagged = 1'b0;

  // Monitor: predicts on accept, checks flags/result/latency every cycle
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      tracking     = 1'b0;
      seen_valid   = 1'b0;
      late_flagged = 1'b0;
      edges        = 0;
    end else begin
      if (tracking) edges++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "spurious_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          chk(Q === exp_q[0].q, "model_q", Q, exp_q[0].q);
          if (!seen_valid) begin
            chk(edges == exp_q[0].lat, "latency", edges, exp_q[0].lat);
            seen_valid = 1'b1;
          end
          chk(in_ready === 1'b0 && busy === 1'b1, "done_flags", {30'd0, in_ready, busy}, 32'd1);
          if (out_ready) begin
            void'(exp_q.pop_front());
            tracking     = 1'b0;
            seen_valid   = 1'b0;
            late_flagged = 1'b0;
          end
        end
      end else if (tracking) begin
        chk(in_ready === 1'b0 && busy === 1'b1, "calc_flags", {30'd0, in_ready, busy}, 32'd1);
        if (!late_flagged && exp_q.size() > 0 && edges > exp_q[0].lat) begin
          chk(1'b0, "latency_late", edges, exp_q[0].lat);
          late_flagged = 1'b1;
        end
      end else begin
        chk(in_ready === 1'b1 && busy === 1'b0, "idle_flags", {30'd0, in_ready, busy}, 32'd2);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{model_q(func, A, B), model_lat(func, A, B)});
        tracking     = 1'b1;
        edges        = 0;
        seen_valid   = 1'b0;
        late_flagged = 1'b0;
      end
    end
  end

  // Present an operation and hold it until accepted; returns one cycle after accept
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; func = f; A = a; B = b;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = in_ready;
    end
    if (!got) chk(1'b0, "accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom;
  endtask

  // Wait for a result, check the literal, stall `hold` cycles, then consume
  task automatic wait_result(input logic [31:0] lit, input string name, input int hold);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = out_valid;
    end
    if (!got) begin
      chk(1'b0, {name, "_timeout"}, {31'd0, out_valid}, 32'd1);
    end else begin
      chk(Q === lit, name, Q, lit);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk(Q === lit && out_valid === 1'b1 && in_ready === 1'b0, {name, "_hold"}, Q, lit);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk(in_ready === 1'b1 && out_valid === 1'b0, {name, "_release"}, {30'd0, in_ready, out_valid}, 32'd2);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(in_ready === 1'b1,  "rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk(out_valid === 1'b0, "rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk(busy === 1'b0,      "rst_busy",      {31'd0, busy},      32'd0);
    chk(Q === 32'd0,        "rst_q",         Q,                  32'd0);

    issue(3'd0, 32'd7, 32'hFFFFFFFD);        wait_result(32'hFFFFFFEB, "mul", 0);
    issue(3'd1, 32'h80000000, 32'h80000000); wait_result(32'h40000000, "mulh", 0);
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_result(32'hFFFFFFFE, "mulhu", 0);
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_result(32'hFFFFFFFF, "mulhsu", 0);
    issue(3'd4, 32'hFFFFFFF9, 32'd2);        wait_result(32'hFFFFFFFD, "div", 0);
    issue(3'd6, 32'hFFFFFFF9, 32'd2);        wait_result(32'hFFFFFFFF, "rem", 0);
    issue(3'd5, 32'd100, 32'd7);             wait_result(32'd14, "divu", 0);
    issue(3'd7, 32'd100, 32'd7);             wait_result(32'd2, "remu", 0);

    issue(3'd5, 32'h1234, 32'd0);            wait_result(32'hFFFFFFFF, "divu_by0", 0);
    issue(3'd6, 32'h1234, 32'd0);            wait_result(32'h1234, "rem_by0", 0);
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF); wait_result(32'h80000000, "div_ovf", 0);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF); wait_result(32'd0, "rem_ovf", 0);

    // backpressure in DONE
    issue(3'd5, 32'd100, 32'd7);             wait_result(32'd14, "divu_bp", 10);

    // inputs wiggle and out_ready pulses while calculating
    issue(3'd4, 32'hFFFFFFF9, 32'd2);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      A = $urandom; B = $urandom; func = 3'($urandom);
      in_valid  = 1'($urandom);
      out_ready = (i < 5);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    wait_result(32'hFFFFFFFD, "div_noisy_inputs", 0);

    // reset in the middle of a calculation
    issue(3'd5, 32'hFFFFFFFF, 32'd3);
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk(in_ready === 1'b1,  "abort_in_ready",  {31'd0, in_ready},  32'd1);
    chk(out_valid === 1'b0, "abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk(Q === 32'd0,        "abort_q",         Q,                  32'd0);
    issue(3'd0, 32'd3, 32'd5);               wait_result(32'd15, "mul_after_abort", 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
